nibble_uart_tx: RTL and testbench

//  Serial transmitter for a 4-bit parallel word: accepts a nibble over a

---
 rtl/nibble_uart_tx_pkg.sv | 20 ++
 rtl/nibble_uart_tx_baud_tick.sv | 37 +++
 rtl/nibble_uart_tx.sv | 132 +++++++++++++
 tb/tb_nibble_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/nibble_uart_tx_pkg.sv
// Shared definitions for the nibble serial link: FSM state encoding and the
// default bit period, kept here so the future receiver uses the same values.
package nibble_uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Bit value that makes the total count of ones (nibble + bit) even.
    function automatic logic even_parity(input logic [3:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/nibble_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clr is high, so a period starts cleanly on release.
module nibble_uart_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/nibble_uart_tx.sv
// Nibble UART transmitter: start bit, 4 data bits LSB first, optional even
// parity, stop bit. All outputs come straight from flops.
module nibble_uart_tx
    import nibble_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic [3:0] shift_q, shift_d;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_tick;

    // The period counter restarts whenever the FSM leaves IDLE; every other
    // state change happens on a terminal count, where it wraps to zero anyway.
    nibble_uart_tx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_q == ST_IDLE),
        .tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (valid && ready_q) begin
                    shift_d   = data_in;
                    parity_d  = even_parity(data_in);
                    bit_idx_d = 2'd0;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 2'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 2'd3) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        // tx is registered, so present the next bit one shift ahead
                        shift_d   = {1'b0, shift_q[3:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 2'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= 4'd0;
            bit_idx_q <= 2'd0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Bench for nibble_uart_tx: two instances (parity on / off) at 4 clocks per
// bit, checked cycle by cycle against a frame model built from bit lists.
module tb_nibble_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] data0 = 4'd0, data1 = 4'd0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [1:0] ready_w, tx_w, busy_w, done_w;

    int total = 0;
    int bad = 0;
    int frames_sent [2] = '{0, 0};
    int done_seen [2] = '{0, 0};

    always #5 clk = ~clk;

    nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_par (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .valid(valid0),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut_nopar (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .valid(valid1),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    always @(negedge clk) begin
        if (done_w[0]) done_seen[0]++;
        if (done_w[1]) done_seen[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [3:0] d);
        if (sel == 0) begin
            valid0 = v;
            data0  = d;
        end else begin
            valid1 = v;
            data1  = d;
        end
    endtask

    // Reference frame: list of line levels, one entry per bit period.
    task automatic build_frame(input logic [3:0] d, input int pe, output bit bits [7], output int nbits);
        nbits = 6 + pe;
        bits[0] = 1'b0;
        for (int i = 0; i < 4; i++) bits[1 + i] = d[i];
        if (pe != 0) bits[5] = ($countones(d) % 2) == 1;
        bits[nbits - 1] = 1'b1;
    endtask

    // Called at a negedge; raises valid, checks the whole frame and the done
    // cycle. With hold_next, valid stays high into the done cycle carrying next_d.
    task automatic send_frame(input int sel, input logic [3:0] d, input bit hold_next,
                              input logic [3:0] next_d);
        bit bits [7];
        int nbits;
        int len;
        build_frame(d, (sel == 0) ? 1 : 0, bits, nbits);
        len = nbits * CPB;
        drive(sel, 1'b1, d);
        chk("ready_pre", 32'(ready_w[sel]), 32'd1);
        @(negedge clk);
        chk("busy_start", 32'(busy_w[sel]), 32'd1);
        for (int c = 0; c < len; c++) begin
            chk($sformatf("tx_dut%0d_c%0d", sel, c), 32'(tx_w[sel]), 32'(bits[c / CPB]));
            chk("done_mid", 32'(done_w[sel]), 32'd0);
            if (c == len - 1)
                drive(sel, hold_next, next_d);
            else
                drive(sel, hold_next ? 1'b1 : 1'($urandom_range(0, 1)), 4'($urandom));
            @(negedge clk);
        end
        chk("done_pulse", 32'(done_w[sel]), 32'd1);
        chk("ready_post", 32'(ready_w[sel]), 32'd1);
        chk("busy_post", 32'(busy_w[sel]), 32'd0);
        chk("tx_post", 32'(tx_w[sel]), 32'd1);
        frames_sent[sel]++;
        $display("frame dut%0d data=%h parity_en=%0d len=%0d hold=%0d", sel, d,
                 (sel == 0) ? 1 : 0, len, hold_next);
        if (!hold_next) begin
            @(negedge clk);
            chk("done_width", 32'(done_w[sel]), 32'd0);
            chk("idle_tx", 32'(tx_w[sel]), 32'd1);
        end
    endtask

    initial begin
        logic [3:0] cur, nxt;
        bit hold;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_tx", 32'(tx_w[s]), 32'd1);
            chk("rst_ready", 32'(ready_w[s]), 32'd1);
            chk("rst_busy", 32'(busy_w[s]), 32'd0);
            chk("rst_done", 32'(done_w[s]), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx_w[0] & tx_w[1]), 32'd1);
        end
        $display("reset and idle checked");

        send_frame(0, 4'b1010, 1'b0, 4'd0);
        send_frame(0, 4'b0111, 1'b0, 4'd0);
        send_frame(1, 4'b0111, 1'b0, 4'd0);

        // back-to-back: F then 0, data_in scrambled while the first is busy
        send_frame(0, 4'hF, 1'b1, 4'h0);
        send_frame(0, 4'h0, 1'b0, 4'd0);
        send_frame(1, 4'hF, 1'b1, 4'h0);
        send_frame(1, 4'h0, 1'b0, 4'd0);

        // abort during data bit 2, which is the fourth bit period of the frame
        drive(0, 1'b1, 4'hA);
        @(negedge clk);
        drive(0, 1'b0, 4'd0);
        for (int c = 0; c < 3 * CPB + 1; c++) @(negedge clk);
        chk("abort_pre_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_w[0]), 32'd1);
        chk("abort_ready", 32'(ready_w[0]), 32'd1);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_done", 32'(done_w[0]), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * 7 * CPB; c++) begin
            @(negedge clk);
            chk("post_abort_tx", 32'(tx_w[0]), 32'd1);
            chk("post_abort_done", 32'(done_w[0]), 32'd0);
        end
        $display("abort checked");
        send_frame(0, 4'h5, 1'b0, 4'd0);

        // randomized chains, random back-to-back decisions
        for (int s = 0; s < 2; s++) begin
            cur = 4'($urandom);
            for (int i = 0; i < 8; i++) begin
                nxt  = 4'($urandom);
                hold = (i < 7) && ($urandom_range(0, 1) == 1);
                send_frame(s, cur, hold, nxt);
                cur = nxt;
            end
        end

        repeat (3) @(negedge clk);
        chk("done_count0", 32'(done_seen[0]), 32'(frames_sent[0]));
        chk("done_count1", 32'(done_seen[1]), 32'(frames_sent[1]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
